// File: rtl/riscv_pkg.sv
// Shared RV32I fetch types: FSM state encoding, IF/ID payload and reset defaults.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

    // Bubble entry: NOP with cleared PC fields, marked not valid
    function automatic if_id_t bubble_entry(input logic [XLEN-1:0] nop);
        if_id_t e;
        e.instr = nop;
        e.pc    = '0;
        e.pc4   = '0;
        e.valid = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory port between the fetch stage (master) and imem (slave).
interface fetch_stage_if
    import riscv_pkg::*;
;
    logic [XLEN-1:0] imem_addr_o;
    logic [XLEN-1:0] imem_rdata_i;
    logic            imem_ready_i;

    modport master (output imem_addr_o, input imem_rdata_i, input imem_ready_i);
    modport slave  (input imem_addr_o, output imem_rdata_i, output imem_ready_i);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats load.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            q <= bubble_entry(NOP_INSTR);
        end else if (load && !hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC register, BOOT/RUN/HALT control and IF/ID fill.
// Optional FETCH_PERF_CNT_EN adds fetch and bubble counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    input  logic                stall_i,
    fetch_stage_if.master       imem,
    output logic [XLEN-1:0]     if_id_instr_o,
    output logic [XLEN-1:0]     if_id_pc_o,
    output logic [XLEN-1:0]     if_id_pc4_o,
    output logic                if_id_valid_o,
    output logic                flush_idex_o,
    output logic                fetch_fault_o,
    output logic [1:0]          state_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0]     fetch_cnt_o,
    output logic [XLEN-1:0]     bubble_cnt_o
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
    logic            load, hold, bubble;
    if_id_t          if_id_d, if_id_q;

    assign pc_plus4         = pc_q + XLEN'(4);
    assign imem.imem_addr_o = pc_q;

    // Priority within RUN: redirect > stall > imem wait > advance
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        load         = 1'b0;
        hold         = 1'b0;
        bubble       = 1'b0;
        flush_idex_o = 1'b0;
        case (state_q)
            BOOT: begin
                bubble  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (redirect_i) begin
                    bubble       = 1'b1;
                    flush_idex_o = 1'b1;
                    if (redirect_pc_i[1:0] == 2'b00) begin
                        pc_d = redirect_pc_i;
                    end else begin
                        state_d = HALT;
                    end
                end else if (stall_i) begin
                    hold = 1'b1;
                end else if (!imem.imem_ready_i) begin
                    bubble = 1'b1;
                end else begin
                    load = 1'b1;
                    pc_d = pc_plus4;
                end
            end
            HALT: begin
                bubble = 1'b1;
            end
            default: begin
                bubble  = 1'b1;
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            fetch_fault_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_fault_o <= (state_d == HALT);
        end
    end

    assign if_id_d = '{instr: imem.imem_rdata_i, pc: pc_q, pc4: pc_plus4, valid: 1'b1};

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .hold   (hold),
        .bubble (bubble),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    assign if_id_instr_o = if_id_q.instr;
    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_pc4_o   = if_id_q.pc4;
    assign if_id_valid_o = if_id_q.valid;
    assign state_o       = 2'(state_q);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (load) begin
                fetch_cnt_o <= fetch_cnt_o + XLEN'(1);
            end
            if (bubble) begin
                bubble_cnt_o <= bubble_cnt_o + XLEN'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with an expected-result queue.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [1:0]  S_BOOT = 2'd0;
    localparam logic [1:0]  S_RUN  = 2'd1;
    localparam logic [1:0]  S_HALT = 2'd2;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] addr;
        logic [1:0]  state;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic [31:0] if_id_instr_o, if_id_pc_o, if_id_pc4_o;
    logic        if_id_valid_o, flush_idex_o, fetch_fault_o;
    logic [1:0]  state_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_o, bubble_cnt_o;
`endif

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .imem          (imem.master),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_valid_o (if_id_valid_o),
        .flush_idex_o  (flush_idex_o),
        .fetch_fault_o (fetch_fault_o),
        .state_o       (state_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o   (fetch_cnt_o),
        .bubble_cnt_o  (bubble_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1357_0013);
    endfunction

    always_comb imem.imem_rdata_i = mem(imem.imem_addr_o);

    function automatic exp_t bub(input logic [31:0] addr, input logic [1:0] st, input logic flt);
        exp_t e;
        e = '{instr: NOP, pc: 32'h0, pc4: 32'h0, valid: 1'b0, addr: addr, state: st, fault: flt};
        return e;
    endfunction

    // IF/ID holding the instruction at p, fetch address addr, state RUN
    function automatic exp_t ent(input logic [31:0] p, input logic [31:0] addr);
        exp_t e;
        e = '{instr: mem(p), pc: p, pc4: p + 32'd4, valid: 1'b1, addr: addr, state: S_RUN, fault: 1'b0};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check the combinational flush, then compare post-edge state
    task automatic cyc(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic stall, input logic rdy, input logic fl_chk,
                       input logic exp_flush, input exp_t e);
        exp_t got;
        rst_n             = rst;
        redirect_i        = redir;
        redirect_pc_i     = rpc;
        stall_i           = stall;
        imem.imem_ready_i = rdy;
        #1;
        if (fl_chk) chk("flush_idex", 32'(flush_idex_o), 32'(exp_flush));
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("if_id_instr", if_id_instr_o, got.instr);
        chk("if_id_pc", if_id_pc_o, got.pc);
        chk("if_id_pc4", if_id_pc4_o, got.pc4);
        chk("if_id_valid", 32'(if_id_valid_o), 32'(got.valid));
        chk("imem_addr", imem.imem_addr_o, got.addr);
        chk("state", 32'(state_o), 32'(got.state));
        chk("fetch_fault", 32'(fetch_fault_o), 32'(got.fault));
    endtask

    initial begin
        rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; stall_i = 1'b0;
        imem.imem_ready_i = 1'b1;

        // Reset, then BOOT ignores a redirect and inserts a bubble
        cyc(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, bub(32'h0, S_BOOT, 1'b0));
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt_reset", fetch_cnt_o, 32'd0);
        chk("bubble_cnt_reset", bubble_cnt_o, 32'd0);
`endif
        cyc(1'b1, 1'b1, 32'h80, 1'b0, 1'b1, 1'b1, 1'b0, bub(32'h0, S_RUN, 1'b0));
        cyc(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, ent(32'h0, 32'h4));
        chk("first_instr", if_id_instr_o, 32'h0050_0093);
        cyc(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, ent(32'h4, 32'h8));

        // Imem wait at pc=0x8 for two cycles
        cyc(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, bub(32'h8, S_RUN, 1'b0));
        cyc(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, bub(32'h8, S_RUN, 1'b0));
        cyc(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, ent(32'h8, 32'hC));
        cyc(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, ent(32'hC, 32'h10));

        // Redirect at pc=0x10 overrides stall and wait
        cyc(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1, bub(32'h40, S_RUN, 1'b0));
        cyc(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, ent(32'h40, 32'h44));

        // Stall for 3 cycles with fetch address 0x20
        cyc(1'b1, 1'b1, 32'h1C, 1'b0, 1'b1, 1'b1, 1'b1, bub(32'h1C, S_RUN, 1'b0));
        cyc(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, ent(32'h1C, 32'h20));
        cyc(1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, ent(32'h1C, 32'h20));
        cyc(1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, ent(32'h1C, 32'h20));
        cyc(1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, ent(32'h1C, 32'h20));
        cyc(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, ent(32'h20, 32'h24));
        cyc(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, ent(32'h24, 32'h28));

        // Misaligned redirect halts; HALT ignores redirects; reset recovers
        cyc(1'b1, 1'b1, 32'h42, 1'b0, 1'b1, 1'b1, 1'b1, bub(32'h28, S_HALT, 1'b1));
        cyc(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0, bub(32'h28, S_HALT, 1'b1));
        cyc(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, bub(32'h28, S_HALT, 1'b1));
        cyc(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0, bub(32'h0, S_BOOT, 1'b0));

        // Wrap: BOOT, one fetch, redirect to 0xFFFF_FFFC, one fetch
        cyc(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, bub(32'h0, S_RUN, 1'b0));
        cyc(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, ent(32'h0, 32'h4));
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b1, bub(32'hFFFF_FFFC, S_RUN, 1'b0));
        cyc(1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, ent(32'hFFFF_FFFC, 32'h0));
        chk("wrap_pc4", if_id_pc4_o, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt_o, 32'd2);
        chk("bubble_cnt", bubble_cnt_o, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
